memory_arbiter: RTL and testbench



---
 rtl/memory_arbiter.sv | 124 ++++++++++++
 tb/tb_memory_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Two-master round-robin arbiter/sequencer in front of memory_bus.
// Each grant runs one ACCESS cycle, a bank-dependent number of WAIT cycles, then a one-cycle ACK.
module memory_arbiter #(
  parameter int unsigned RAM_WAIT    = 1,
  parameter int unsigned ROM_WAIT    = 0,
  parameter int unsigned PERIPH_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_write,
  input  logic [15:0] m0_address,
  input  logic [15:0] m0_data_in,
  output logic        m0_ack,
  output logic [15:0] m0_data_out,
  input  logic        m1_req,
  input  logic        m1_write,
  input  logic [15:0] m1_address,
  input  logic [15:0] m1_data_in,
  output logic        m1_ack,
  output logic [15:0] m1_data_out,
  output logic [15:0] bus_address,
  output logic [15:0] bus_data_in,
  input  logic [15:0] bus_data_out,
  output logic        bus_enable,
  output logic        bus_write_enable,
  output logic        busy,
  output logic        grant
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;

  state_t      state;
  logic        last;
  logic        write_q;
  logic [3:0]  wait_cnt;
  logic        any_req;
  logic        pick;
  logic        pick_write;
  logic [15:0] pick_address;
  logic [15:0] pick_data;
  logic        last_cycle;

  function automatic logic [3:0] bank_wait(input logic [1:0] bank);
    case (bank)
      2'b01:   return 4'(ROM_WAIT);
      2'b10:   return 4'(PERIPH_WAIT);
      default: return 4'(RAM_WAIT);
    endcase
  endfunction

  // On a tie the master that did not win last time is chosen.
  always_comb begin
    any_req      = m0_req | m1_req;
    pick         = (m0_req & m1_req) ? ~last : m1_req;
    pick_write   = pick ? m1_write   : m0_write;
    pick_address = pick ? m1_address : m0_address;
    pick_data    = pick ? m1_data_in : m0_data_in;
    last_cycle   = ((state == ACCESS) && (wait_cnt == '0)) ||
                   ((state == WAIT)   && (wait_cnt == 4'd1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      last             <= 1'b1;
      write_q          <= 1'b0;
      wait_cnt         <= '0;
      grant            <= 1'b0;
      busy             <= 1'b0;
      bus_address      <= '0;
      bus_data_in      <= '0;
      bus_enable       <= 1'b0;
      bus_write_enable <= 1'b0;
      m0_ack           <= 1'b0;
      m1_ack           <= 1'b0;
      m0_data_out      <= '0;
      m1_data_out      <= '0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant            <= pick;
            last             <= pick;
            write_q          <= pick_write;
            bus_address      <= pick_address;
            bus_data_in      <= pick_data;
            wait_cnt         <= bank_wait(pick_address[14:13]);
            bus_enable       <= 1'b1;
            bus_write_enable <= pick_write;
            busy             <= 1'b1;
            state            <= ACCESS;
          end
        end
        ACCESS, WAIT: begin
          bus_write_enable <= 1'b0;
          if (state == WAIT) wait_cnt <= wait_cnt - 4'd1;
          // Last bus cycle: capture read data for the owner and raise its ack.
          if (last_cycle) begin
            bus_enable <= 1'b0;
            state      <= ACK;
            if (grant) begin
              m1_ack <= 1'b1;
              if (!write_q) m1_data_out <= bus_data_out;
            end else begin
              m0_ack <= 1'b1;
              if (!write_q) m0_data_out <= bus_data_out;
            end
          end else begin
            state <= WAIT;
          end
        end
        ACK: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: drivers push expected acks/writes, a negedge monitor pops and compares.
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m0_req, m0_write, m1_req, m1_write;
  logic [15:0] m0_address, m0_data_in, m1_address, m1_data_in;
  logic        m0_ack, m1_ack;
  logic [15:0] m0_data_out, m1_data_out;
  logic [15:0] bus_address, bus_data_in, bus_data_out;
  logic        bus_enable, bus_write_enable, busy, grant;
  logic [69:0] all_outs;

  always #5 clk = ~clk;

  memory_arbiter #(.RAM_WAIT(1), .ROM_WAIT(0), .PERIPH_WAIT(1)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_write(m0_write), .m0_address(m0_address), .m0_data_in(m0_data_in),
    .m0_ack(m0_ack), .m0_data_out(m0_data_out),
    .m1_req(m1_req), .m1_write(m1_write), .m1_address(m1_address), .m1_data_in(m1_data_in),
    .m1_ack(m1_ack), .m1_data_out(m1_data_out),
    .bus_address(bus_address), .bus_data_in(bus_data_in), .bus_data_out(bus_data_out),
    .bus_enable(bus_enable), .bus_write_enable(bus_write_enable), .busy(busy), .grant(grant)
  );

  assign all_outs = {m0_ack, m0_data_out, m1_ack, m1_data_out, bus_address, bus_data_in,
                     bus_enable, bus_write_enable, busy, grant};

  // Memory stand-in: fixed read contents keyed by the low address nibble.
  function automatic logic [15:0] rd_table(input logic [3:0] i);
    case (i)
      4'h0:    return 16'h5A5A;
      4'h5:    return 16'h1234;
      4'h7:    return 16'h7777;
      4'h9:    return 16'h9999;
      4'hA:    return 16'hAAAA;
      4'hB:    return 16'hBBBB;
      4'hC:    return 16'hCCCC;
      4'hD:    return 16'hDDDD;
      4'hE:    return 16'hEEEE;
      4'hF:    return 16'hF0F0;
      default: return 16'h0BAD;
    endcase
  endfunction
  assign bus_data_out = rd_table(bus_address[3:0]);

  typedef struct {
    bit          master;
    logic [15:0] data;
    int          exp_cyc;
    int          exp_en;
  } ack_t;
  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  ack_t aq[$];
  wr_t  wq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   wcount = 0;
  int   en_cnt = 0;
  int   wc_at_reset = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus_write_enable) wcount <= wcount + 1;
  end

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_ack(input bit m, input logic [15:0] d, input int ec, input int en);
    ack_t e;
    e.master = m; e.data = d; e.exp_cyc = ec; e.exp_en = en;
    aq.push_back(e);
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [15:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    wq.push_back(w);
  endtask

  // Requester: raise req, wait (bounded) for own ack, drop req on that cycle unless hold is set.
  task automatic drive(input bit m, input bit wr, input logic [15:0] a, input logic [15:0] d,
                       input bit hold);
    bit got;
    got = 1'b0;
    if (!m) begin
      m0_req = 1'b1; m0_write = wr; m0_address = a; m0_data_in = d;
    end else begin
      m1_req = 1'b1; m1_write = wr; m1_address = a; m1_data_in = d;
    end
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = m ? m1_ack : m0_ack;
    end
    check(m ? "m1_ack_arrived" : "m0_ack_arrived", {79'd0, got}, 80'd1);
    if (!hold) begin
      if (!m) m0_req = 1'b0;
      else    m1_req = 1'b0;
    end
  endtask

  // Monitor: compares every write strobe and every ack against the queues.
  initial begin
    wr_t  w;
    ack_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        en_cnt = 0;
      end else begin
        if (bus_enable) en_cnt++;
        if (bus_write_enable) begin
          if (wq.size() == 0) begin
            check("unexpected_write", {64'd0, bus_address}, 80'd0);
          end else begin
            w = wq.pop_front();
            check("write_addr", {64'd0, bus_address}, {64'd0, w.addr});
            check("write_data", {64'd0, bus_data_in}, {64'd0, w.data});
          end
        end
        if (m0_ack || m1_ack) begin
          if (aq.size() == 0) begin
            check("unexpected_ack", {78'd0, m1_ack, m0_ack}, 80'd0);
          end else begin
            e = aq.pop_front();
            check("ack_owner", {78'd0, m1_ack, m0_ack}, e.master ? 80'd2 : 80'd1);
            check("grant", {79'd0, grant}, {79'd0, e.master});
            check("data_out", {64'd0, (e.master ? m1_data_out : m0_data_out)}, {64'd0, e.data});
            check("bus_enable_cycles", 80'(en_cnt), 80'(e.exp_en));
            if (e.exp_cyc != 0) check("ack_latency", 80'(cyc), 80'(e.exp_cyc));
          end
          en_cnt = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    m0_req = 1'b0; m0_write = 1'b0; m0_address = '0; m0_data_in = '0;
    m1_req = 1'b0; m1_write = 1'b0; m1_address = '0; m1_data_in = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {10'd0, all_outs}, 80'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single read, RAM bank (W=1): ack at W+2 edges after issue, 2 enable cycles.
    push_ack(1'b0, 16'h1234, cyc + 3, 2);
    drive(1'b0, 1'b0, 16'h0005, 16'h0000, 1'b0);
    repeat (3) @(negedge clk);

    // ROM read by master 1 (W=0).
    push_ack(1'b1, 16'h5A5A, cyc + 2, 1);
    drive(1'b1, 1'b0, 16'h2010, 16'h0000, 1'b0);
    repeat (3) @(negedge clk);

    // Peripheral write: one strobe, data_out keeps the earlier read value.
    push_wr(16'h4003, 16'hBEEF);
    push_ack(1'b0, 16'h1234, cyc + 3, 2);
    drive(1'b0, 1'b1, 16'h4003, 16'hBEEF, 1'b0);
    check("m1_data_out_kept", {64'd0, m1_data_out}, {64'd0, 16'h5A5A});
    repeat (3) @(negedge clk);

    // Back-to-back: req stays high through ack; second grant one IDLE cycle after ACK.
    push_ack(1'b0, 16'h7777, cyc + 3, 2);
    drive(1'b0, 1'b0, 16'h6007, 16'h0000, 1'b1);
    push_ack(1'b0, 16'h9999, cyc + 4, 2);
    drive(1'b0, 1'b0, 16'h0009, 16'h0000, 1'b0);
    repeat (3) @(negedge clk);

    // Reset during WAIT: outputs clear at once, no ack, no further write strobe.
    push_wr(16'h4001, 16'hDEAD);
    m0_req = 1'b1; m0_write = 1'b1; m0_address = 16'h4001; m0_data_in = 16'hDEAD;
    repeat (2) @(negedge clk);
    check("wait_state_bus", {77'd0, busy, bus_enable, bus_write_enable}, 80'b110);
    #1 reset = 1'b0;
    #1 check("reset_midop_outputs", {10'd0, all_outs}, 80'd0);
    wc_at_reset = wcount;
    m0_req = 1'b0; m0_write = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check("no_write_after_reset", 80'(wcount), 80'(wc_at_reset));
    check("idle_after_reset", {79'd0, busy}, 80'd0);

    // Contention from reset (last=1): grants alternate 0,1,0,1,0,1.
    push_ack(1'b0, 16'hAAAA, 0, 2);
    push_ack(1'b1, 16'hDDDD, 0, 2);
    push_ack(1'b0, 16'hBBBB, 0, 1);
    push_ack(1'b1, 16'hEEEE, 0, 1);
    push_ack(1'b0, 16'hCCCC, 0, 2);
    push_ack(1'b1, 16'hF0F0, 0, 2);
    fork
      begin
        drive(1'b0, 1'b0, 16'h000A, 16'h0000, 1'b1);
        drive(1'b0, 1'b0, 16'h200B, 16'h0000, 1'b1);
        drive(1'b0, 1'b0, 16'h400C, 16'h0000, 1'b0);
      end
      begin
        drive(1'b1, 1'b0, 16'h600D, 16'h0000, 1'b1);
        drive(1'b1, 1'b0, 16'h200E, 16'h0000, 1'b1);
        drive(1'b1, 1'b0, 16'h000F, 16'h0000, 1'b0);
      end
    join
    repeat (5) @(negedge clk);
    check("ack_queue_drained", 80'(aq.size()), 80'd0);
    check("write_queue_drained", 80'(wq.size()), 80'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
